// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, exponent landmarks used by
// the float-to-int path, integer saturation limits and the ftoi class encoding.
package fpu_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int EXP_WIDTH   = 8;
    localparam int FRA_WIDTH   = 23;
    localparam int MANT_WIDTH  = 24;
    localparam int INT_WIDTH   = 32;
    localparam int SHAMT_WIDTH = 5;

    localparam logic [EXP_WIDTH-1:0] EXP_BIAS         = 8'd127;
    // Largest exponent whose value still fits in int32 (|x| < 2^31).
    localparam logic [EXP_WIDTH-1:0] FTOI_EXP_MAX     = 8'd157;
    // Exponent at which the 24-bit mantissa is already an integer unshifted.
    localparam logic [EXP_WIDTH-1:0] FTOI_EXP_NOSHIFT = 8'd150;
    localparam logic [EXP_WIDTH-1:0] EXP_SPECIAL      = 8'hFF;

    localparam logic [INT_WIDTH-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    // The one out-of-range operand that still has an exact int32 image (-2^31).
    localparam logic [FP_WIDTH-1:0] FP_NEG_2P31 = 32'hCF00_0000;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_SAT    = 2'd2,
        CLS_NAN    = 2'd3
    } ftoi_class_e;

    // Class of an operand from its exponent and fraction fields only.
    function automatic ftoi_class_e ftoi_classify(
        input logic [EXP_WIDTH-1:0] exp,
        input logic [FRA_WIDTH-1:0] fra
    );
        ftoi_class_e cls;
        if (exp == EXP_SPECIAL) begin
            cls = (fra != '0) ? CLS_NAN : CLS_SAT;
        end else if (exp > FTOI_EXP_MAX) begin
            cls = CLS_SAT;
        end else if (exp < EXP_BIAS) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ftoi_shift.sv
// Combinational barrel shifter placing the 24-bit mantissa into a 32-bit
// magnitude. Right shifts truncate (round toward zero); left shifts are only
// ever used for small amounts so the result never exceeds 31 bits.
module ftoi_shift
    import fpu_pkg::*;
(
    input  logic [MANT_WIDTH-1:0]  m,
    input  logic [SHAMT_WIDTH-1:0] amt,
    input  logic                   left,
    output logic [INT_WIDTH-1:0]   mag
);

    // lvl[k] holds the value after the shift bits below k have been applied.
    logic [SHAMT_WIDTH:0][INT_WIDTH-1:0] lvl;

    assign lvl[0] = {{(INT_WIDTH-MANT_WIDTH){1'b0}}, m};

    // One log-shifter stage per amount bit, shifting by 2^gi in the chosen direction.
    generate
        for (genvar gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            always_comb begin
                if (!amt[gi]) begin
                    lvl[gi+1] = lvl[gi];
                end else if (left) begin
                    lvl[gi+1] = lvl[gi] << SH;
                end else begin
                    lvl[gi+1] = lvl[gi] >> SH;
                end
            end
        end
    endgenerate

    assign mag = lvl[SHAMT_WIDTH];

endmodule

// File: rtl/ftoi.sv
// Two-stage binary32 -> int32 converter, round toward zero with saturation.
// Stage 1 classifies and derives the shift from the exponent; stage 2 shifts,
// applies the sign and selects the saturated/special value.
module ftoi
    import fpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FP_WIDTH-1:0]  op,
    input  logic                 valid,
    output logic [INT_WIDTH-1:0] result,
    output logic                 ready,
    output logic                 ovf
);

    // ---------------- stage 1: classify and plan the shift ----------------
    logic                   op_sig;
    logic [EXP_WIDTH-1:0]   op_exp;
    logic [FRA_WIDTH-1:0]   op_fra;
    logic [EXP_WIDTH-1:0]   exp_up;
    logic [EXP_WIDTH-1:0]   exp_dn;

    ftoi_class_e            cls_next;
    logic [SHAMT_WIDTH-1:0] amt_next;
    logic                   left_next;
    logic                   exact_min_next;

    ftoi_class_e            cls_reg;
    logic                   valid1_reg;
    logic                   sig1_reg;
    logic [MANT_WIDTH-1:0]  m1_reg;
    logic [SHAMT_WIDTH-1:0] amt1_reg;
    logic                   left1_reg;
    logic                   exact_min1_reg;

    assign op_sig = op[31];
    assign op_exp = op[30:23];
    assign op_fra = op[22:0];

    assign exp_up = op_exp - FTOI_EXP_NOSHIFT;
    assign exp_dn = FTOI_EXP_NOSHIFT - op_exp;

    // Shift plan; only meaningful for NORMAL operands, zeroed otherwise.
    always_comb begin
        cls_next       = ftoi_classify(op_exp, op_fra);
        amt_next       = '0;
        left_next      = 1'b0;
        exact_min_next = (op == FP_NEG_2P31);
        if (cls_next == CLS_NORMAL) begin
            if (op_exp > FTOI_EXP_NOSHIFT) begin
                left_next = 1'b1;
                amt_next  = exp_up[SHAMT_WIDTH-1:0];
            end else begin
                amt_next  = exp_dn[SHAMT_WIDTH-1:0];
            end
        end
    end

    // Stage-1 pipeline registers; data only loads when an operand is present.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1_reg     <= 1'b0;
            cls_reg        <= CLS_ZERO;
            sig1_reg       <= 1'b0;
            m1_reg         <= '0;
            amt1_reg       <= '0;
            left1_reg      <= 1'b0;
            exact_min1_reg <= 1'b0;
        end else begin
            valid1_reg <= valid;
            if (valid) begin
                cls_reg        <= cls_next;
                sig1_reg       <= op_sig;
                m1_reg         <= {1'b1, op_fra};
                amt1_reg       <= amt_next;
                left1_reg      <= left_next;
                exact_min1_reg <= exact_min_next;
            end
        end
    end

    // ---------------- stage 2: shift, negate, saturate ----------------
    logic [INT_WIDTH-1:0] mag;
    logic [INT_WIDTH-1:0] signed_mag;
    logic [INT_WIDTH-1:0] result_next;
    logic                 ovf_next;

    ftoi_shift u_shift (
        .m    (m1_reg),
        .amt  (amt1_reg),
        .left (left1_reg),
        .mag  (mag)
    );

    assign signed_mag = sig1_reg ? (~mag + 32'd1) : mag;

    // Final value per class; -2^31 saturates to INT_MIN without flagging overflow.
    always_comb begin
        result_next = '0;
        ovf_next    = 1'b0;
        case (cls_reg)
            CLS_ZERO: begin
                result_next = '0;
                ovf_next    = 1'b0;
            end
            CLS_NORMAL: begin
                result_next = signed_mag;
                ovf_next    = 1'b0;
            end
            CLS_SAT: begin
                result_next = sig1_reg ? INT_MIN : INT_MAX;
                ovf_next    = !exact_min1_reg;
            end
            CLS_NAN: begin
                result_next = INT_MAX;
                ovf_next    = 1'b1;
            end
            default: begin
                result_next = '0;
                ovf_next    = 1'b0;
            end
        endcase
    end

    // Output registers: ready pulses per completed operand, result/ovf hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            ovf    <= 1'b0;
            ready  <= 1'b0;
        end else begin
            ready <= valid1_reg;
            if (valid1_reg) begin
                result <= result_next;
                ovf    <= ovf_next;
            end
        end
    end

endmodule

// File: doc/ftoi.md
# ftoi

Pipelined single-precision float to signed 32-bit integer converter with round-toward-zero and saturation. It sits directly downstream of the `floor` unit in the FPU. `floor` output fed here yields floor-to-int, which is exact because `floor` results are integral. It also serves as the standalone `ftoi` instruction unit. Throughput is one operand per cycle, latency is 2 cycles, and a one-cycle `ready` pulse accompanies each result.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `op` in 32: IEEE-754 binary32 operand, sampled when `valid`=1.
- `valid` in 1: operand-present strobe; may be held high for back-to-back issue.
- `result` out 32: two's-complement integer; held between results.
- `ready` out 1: one-cycle pulse marking `result`/`ovf` valid.
- `ovf` out 1: set with `ready` when the input was NaN, ±Inf or out of int32 range.

## Operation
- Field split: sig=op[31], exp=op[30:23], fra=op[22:0]; mantissa m={1,fra} (24 bits).
- Classification (stage 1):
  - ZERO: exp<=126, including ±0 and denormals. Result 0, ovf=0.
  - NAN: exp=255 and fra!=0. Result 0x7FFFFFFF, ovf=1.
  - SAT: exp=255 with fra=0, or exp>=158. Result 0x7FFFFFFF if sig=0, else 0x80000000. ovf=1, except op=0xCF000000 (exactly -2^31), which gives 0x80000000 with ovf=0.
  - NORMAL: 127<=exp<=157.
- NORMAL magnitude:
  - If exp<=150: mag = m >> (150-exp). Right shift of 0..23; discarded bits are truncated, never rounded.
  - If exp>150: mag = m << (exp-150). Left shift of 1..7; mag fits in 31 bits.
- Sign apply: result = sig ? (~mag+1) : mag, computed in 32 bits.
- Stage 1 registers: valid1, class (2 bits), sig1, m1[23:0], a shift amount, and a shift-direction bit. The shift amount is 5 bits and the direction bit marks left vs right.
- Stage 2 registers: barrel shift, negate and saturation mux, then result, ovf and ready<=valid1.
- No back-pressure. The consumer must accept every `ready` pulse.

## Timing
- Reset values: result=0, ready=0, ovf=0; valid1=0, class=ZERO, all stage-1 data 0.
- `valid` sampled at edge N means stage-1 valid at N, `ready`=1 after edge N+1, visible during cycle N+2 relative to issue cycle N.
- Back-to-back `valid` on consecutive cycles produces consecutive `ready` pulses, in order, with no bubbles.
- With `valid`=0, `ready` drops to 0 on the next edge. `result` and `ovf` keep their last values.
- `reset` asserted mid-flight drops all in-flight operands; no `ready` follows them. The first operand after reset release completes normally.
- `valid` while `reset`=1 is ignored.
- Combinational depth: stage 1 is compare/subtract on exp only. Stage 2 is a 24→32 shifter plus a 32-bit increment.

## Structure
- Shared package `fpu_pkg` holds:
  - field widths;
  - `EXP_BIAS`=127, `FTOI_EXP_MAX`=157, `FTOI_EXP_NOSHIFT`=150;
  - `INT_MAX`=32'h7FFFFFFF, `INT_MIN`=32'h80000000;
  - a 2-bit class encoding: ZERO, NORMAL, SAT, NAN.
- One combinational sub-module, `ftoi_shift`. It maps (m[23:0], amt[4:0], left) to mag[31:0] and is instantiated in stage 2. The rest of the block stays in `ftoi`.

## Test plan
- 0x40490FDB (3.14159): valid at cycle 0 → ready at cycle 2, result=0x00000003, ovf=0.
- 0xC0200000 (-2.5) → 0xFFFFFFFE (-2); 0x4B000001 → 0x00800001; 0x4B800001 → 0x01000002.
- Zero class:
  - 0x3F7FFFFF → 0x00000000.
  - 0x80000000 → 0x00000000.
  - 0x00000001 (denormal) → 0x00000000, all with ovf=0.
- Saturation and specials:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, ovf=1.
  - 0xCF000000 → 0x80000000, ovf=0.
  - 0xFF800000 (-Inf) → 0x80000000, ovf=1.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, ovf=1.
- Issue 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on four consecutive cycles → ready high cycles 2–5, results 1, 2, 3, 4 in order.
- Issue two operands, assert `reset` one cycle later for one cycle → no ready pulse, outputs 0. Then 0x41200000 → 0x0000000A two cycles after issue.
